// File: rtl/alu_mdu_control_pkg.sv
// Shared encodings for the RV32 ALU control: ALU op codes, main-control ALU_Op
// classes, RV32M funct3 codes, MDU sequencer states and the ALU decode function.
package alu_mdu_control_pkg;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_AND    = 4'b0010;
  localparam logic [3:0] ALU_OR     = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SLL    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_SLT    = 4'b1000;
  localparam logic [3:0] ALU_SLTU   = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_I      = 3'b001;
  localparam logic [2:0] ALUOP_LUI    = 3'b010;
  localparam logic [2:0] ALUOP_ADDR   = 3'b011;
  localparam logic [2:0] ALUOP_BRANCH = 3'b100;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // R-type uses funct7[5] for SUB/SRA; I-type only for SRAI; M-ops decode as ADD.
  function automatic logic [3:0] alu_decode(input logic [2:0] alu_op,
                                            input logic [6:0] f7,
                                            input logic [2:0] f3);
    logic [3:0] op;
    op = ALU_ADD;
    case (alu_op)
      ALUOP_R, ALUOP_I: begin
        if ((alu_op == ALUOP_R) && (f7 == F7_MULDIV)) begin
          op = ALU_ADD;
        end else begin
          case (f3)
            3'b000:  op = ((alu_op == ALUOP_R) && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
          endcase
        end
      end
      ALUOP_LUI:    op = ALU_PASS_B;
      ALUOP_ADDR:   op = ALU_ADD;
      ALUOP_BRANCH: op = ALU_SUB;
      default:      op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mdu_control_mdu_iter_core.sv
// Iterative RV32M datapath: operand magnitudes, shift-add multiplier / restoring
// divider sharing one 2*XLEN accumulator, iteration counter and sign fix-up.
module mdu_iter_core
  import alu_mdu_control_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            skip_o,
  output logic            last_o,
  output logic [XLEN-1:0] result_o
);

  localparam int AW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);

  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            a_signed_s, b_signed_s, sa_s, sb_s, neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic            div_zero_s, ovf_s;
  logic [XLEN-1:0] special_s;
  logic [XLEN:0]   mul_sum_s, div_trial_s, div_diff_s;
  logic [AW-1:0]   acc_step_s, prod_s;
  logic [XLEN-1:0] final_s;

  function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  // Issue-time operand preparation and divide special-case detection
  always_comb begin
    a_signed_s = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                 (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    b_signed_s = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
                 (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    sa_s       = a_signed_s & rs1_data_i[XLEN-1];
    sb_s       = b_signed_s & rs2_data_i[XLEN-1];
    a_mag_s    = cneg(sa_s, rs1_data_i);
    b_mag_s    = cneg(sb_s, rs2_data_i);
    // remainder takes the dividend's sign, everything else the product of signs
    neg_s      = funct3_i[2] && funct3_i[1] ? sa_s : (sa_s ^ sb_s);
    div_zero_s = funct3_i[2] && (rs2_data_i == {XLEN{1'b0}});
    ovf_s      = funct3_i[2] && !funct3_i[0] &&
                 (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_s = funct3_i[1] ? rs1_data_i : {XLEN{1'b1}};
    end else begin
      special_s = funct3_i[1] ? {XLEN{1'b0}} : rs1_data_i;
    end
  end

  assign skip_o = div_zero_s | ovf_s;
  assign last_o = (cnt_q == CW'(XLEN - 1));

  // One multiply or divide iteration and the sign-corrected final result
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    div_trial_s = acc_q[AW-1:XLEN-1];
    div_diff_s  = div_trial_s - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (!div_diff_s[XLEN]) begin
        acc_step_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step_s = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
    prod_s = neg_q ? (~acc_step_s + AW'(1)) : acc_step_s;
    case (op_q)
      F3_MUL:                       final_s = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_s = prod_s[AW-1:XLEN];
      F3_DIV, F3_DIVU:              final_s = cneg(neg_q, acc_step_s[XLEN-1:0]);
      F3_REM, F3_REMU:              final_s = cneg(neg_q, acc_step_s[AW-1:XLEN]);
      default:                      final_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state for operands, accumulator, counter and result
  always_comb begin
    op_d    = op_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (start_i) begin
      op_d    = funct3_i;
      neg_d   = neg_s;
      mcand_d = funct3_i[2] ? b_mag_s : a_mag_s;
      acc_d   = {{XLEN{1'b0}}, (funct3_i[2] ? a_mag_s : b_mag_s)};
      cnt_d   = CW'(0);
      if (skip_o) begin
        res_d = special_s;
      end else begin
        res_d = res_q;
      end
    end else if (step_i) begin
      acc_d = acc_step_s;
      cnt_d = cnt_q + CW'(1);
      if (last_o) begin
        res_d = final_s;
      end else begin
        res_d = res_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= 3'b000;
      neg_q   <= 1'b0;
      mcand_q <= {XLEN{1'b0}};
      acc_q   <= {AW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      res_q   <= {XLEN{1'b0}};
    end else begin
      op_q    <= op_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/alu_mdu_control.sv
// Execute-stage ALU control: combinational RV32I decode plus the handshake FSM
// that stalls the pipeline while the iterative RV32M unit runs.
module alu_mdu_control
  import alu_mdu_control_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [6:0]          funct7_i,
  input  logic [2:0]          ALU_Op_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     rs1_data_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  output logic [ALU_OP_W-1:0] ALU_Operation_o,
  output logic [XLEN-1:0]     mdu_result_o,
  output logic                result_sel_o,
  output logic                stall_o,
  output logic                done_o
);

  mdu_state_e state_q, state_d;
  logic       m_op_s, start_s, step_s, skip_s, last_s;

  assign ALU_Operation_o = ALU_OP_W'(alu_decode(ALU_Op_i, funct7_i, funct3_i));

  assign m_op_s  = valid_i && (ALU_Op_i == ALUOP_R) && (funct7_i == F7_MULDIV);
  assign start_s = (state_q == ST_IDLE) && m_op_s && !flush_i;
  assign step_s  = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !flush_i;

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_s),
    .step_i     (step_s),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .skip_o     (skip_s),
    .last_o     (last_s),
    .result_o   (mdu_result_o)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins from every state
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!m_op_s) begin
            state_d = ST_IDLE;
          end else if (skip_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = funct3_i[2] ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL, ST_DIV: begin
          if (last_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = state_q;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    stall_o      = 1'b0;
    done_o       = 1'b0;
    result_sel_o = 1'b0;
    case (state_q)
      ST_IDLE:        stall_o = m_op_s && !flush_i;
      ST_MUL, ST_DIV: stall_o = !flush_i;
      ST_DONE: begin
        done_o       = !flush_i;
        result_sel_o = !flush_i;
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule
